// File: rtl/grid_write_arbiter_pkg.sv
// Shared constants and types for the grid memory write arbiter.
// Requester indices name the three game engines that write the playfield grid.
package grid_write_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Base address of the next-piece preview area in the grid memory.
  localparam int NEXT_PIECE_BASE_ADDR = 232;

  localparam int REQ_PLACER = 0;
  localparam int REQ_MOVER  = 1;
  localparam int REQ_CLEAR  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/grid_rr_pick.sv
// Combinational round-robin search: first requester at or after ptr (wrapping),
// skipping any bit set in exclude.
module grid_rr_pick #(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] exclude,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  logic [N_REQ-1:0] cand;

  assign cand = req & ~exclude;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    // Outer loop walks the search distance from ptr; only one j matches each distance.
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!valid && cand[j] && (((j - int'(ptr) + N_REQ) % N_REQ) == i)) begin
          pick[j] = 1'b1;
          valid   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/grid_write_arbiter.sv
// Round-robin write arbiter for the shared grid memory with a MAX_BURST
// ownership limit and registered write port.
module grid_write_arbiter #(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = grid_write_arbiter_pkg::ADDR_W,
  parameter int DATA_W    = grid_write_arbiter_pkg::DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        preempt,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_data
);

  import grid_write_arbiter_pkg::*;

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_t        state, state_n;
  logic [N_REQ-1:0]  gnt_n, preempt_n, exclude, pick;
  logic              pick_valid;
  logic [PTR_W-1:0]  ptr, ptr_n, pick_ptr;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              owner_req, burst_end;
  logic              wr_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign owner_req = |(req & gnt);
  assign burst_end = (state == ST_OWNED) && owner_req && (cnt == CNT_MAX);
  // A revoked owner sits out one search so someone else gets the grid.
  assign exclude   = burst_end ? gnt : '0;

  grid_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req     (req),
    .exclude (exclude),
    .ptr     (ptr),
    .pick    (pick),
    .valid   (pick_valid)
  );

  // Search for the next round starts just after whoever is picked now.
  always_comb begin
    pick_ptr = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick[j]) pick_ptr = (j == N_REQ - 1) ? '0 : PTR_W'(j + 1);
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    cnt_n     = cnt;
    ptr_n     = ptr;
    preempt_n = '0;
    unique case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_n = ST_OWNED;
          gnt_n   = pick;
          cnt_n   = CNT_ONE;
          ptr_n   = pick_ptr;
        end
      end
      ST_OWNED: begin
        if (!owner_req) begin
          if (pick_valid) begin
            gnt_n = pick;
            cnt_n = CNT_ONE;
            ptr_n = pick_ptr;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = '0;
            cnt_n   = '0;
          end
        end else if (burst_end) begin
          preempt_n = gnt;
          cnt_n     = CNT_ONE;
          // With nobody else waiting the same owner keeps the grid and pointer.
          if (pick_valid) begin
            gnt_n = pick;
            ptr_n = pick_ptr;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    wr_we   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        wr_we   = req_we[k];
        wr_addr = req_addr[k*ADDR_W +: ADDR_W];
        wr_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      preempt <= '0;
      cnt     <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      preempt <= preempt_n;
      cnt     <= cnt_n;
      ptr     <= ptr_n;
    end
  end

  // Address and data hold their last value when nobody owns the grid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (|gnt) begin
      mem_we   <= wr_we;
      mem_addr <= wr_addr;
      mem_data <= wr_data;
    end else begin
      mem_we   <= 1'b0;
    end
  end

endmodule
